// File: rtl/prng_arb_pkg.sv
// Shared types, defaults and round-robin helper for the PRNG share arbiter.
package prng_arb_pkg;

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_e;

  localparam int DEF_NUM_REQ    = 3;
  localparam int DEF_RND_W      = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int MAX_REQ        = 8;
  localparam int STAT_W         = 16;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req at or after ptr, wrapping within n requesters.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [2:0] ptr,
                                    input int n);
    pick_t p;
    int    k;
    p = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        k = int'(ptr) + i;
        if (k >= n) k = k - n;
        if (req[k]) begin
          p.valid = 1'b1;
          p.idx   = 3'(k);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/prng_share_arbiter_fifo.sv
// Zeroizing FIFO: popped and flushed entries are cleared so stale randomness never lingers.
module prng_zero_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     rd_data,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // wr_ptr==rd_ptr only when empty or full, so push and pop never hit the same entry.
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        mem[rd_ptr] <= '0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/prng_share_arbiter.sv
// Round-robin distributor of PRNG words to masked gadgets with burst lock.
// Optional statistics counters are built when PRNG_ARB_STATS_EN is defined.
module prng_share_arbiter
  import prng_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int RND_W      = DEF_RND_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      prng_valid,
  input  logic [RND_W-1:0]          prng_data,
  output logic                      prng_ready,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [RND_W-1:0]          rnd_data,
  output logic [LVL_W-1:0]          level,
`ifdef PRNG_ARB_STATS_EN
  output logic [NUM_REQ*STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0]         stat_stall,
`endif
  output arb_state_e                state
);

  // PRNG side: word moves on prng_valid && prng_ready; ready depends only on level.
  // Gadget side: req is held until the one-cycle gnt pulse that carries rnd_data.
  arb_state_e           state_nx;
  logic [2:0]           rr_ptr, rr_nx, owner, owner_nx, win;
  logic [MAX_REQ-1:0]   req_pad, lock_pad;
  logic [NUM_REQ-1:0]   gnt_nx;
  logic [RND_W-1:0]     fifo_rd;
  logic                 push, pop;
  pick_t                pick;

  function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
    return (idx == 3'(NUM_REQ - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  assign prng_ready = (level != LVL_W'(FIFO_DEPTH));
  assign push       = prng_valid && prng_ready && !flush;

  always_comb begin
    req_pad  = '0;
    lock_pad = '0;
    req_pad[NUM_REQ-1:0]  = req;
    lock_pad[NUM_REQ-1:0] = lock;
  end

  assign pick = rr_pick(req_pad, rr_ptr, NUM_REQ);

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    owner_nx = owner;
    pop      = 1'b0;
    win      = '0;
    if (flush) begin
      state_nx = ARB;
    end else begin
      case (state)
        ARB: begin
          if (level != '0 && pick.valid) begin
            pop   = 1'b1;
            win   = pick.idx;
            rr_nx = wrap_inc(pick.idx);
            if (lock_pad[pick.idx]) begin
              state_nx = LOCK;
              owner_nx = pick.idx;
            end
          end
        end
        LOCK: begin
          // Owner may still take a final word in the cycle it releases the lock.
          if (level != '0 && req_pad[owner]) begin
            pop = 1'b1;
            win = owner;
          end
          if (!lock_pad[owner]) begin
            state_nx = ARB;
            rr_nx    = wrap_inc(owner);
          end
        end
        default: state_nx = ARB;
      endcase
    end
    gnt_nx = pop ? (NUM_REQ'(1) << win) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      gnt      <= '0;
      rnd_data <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_nx;
      owner    <= owner_nx;
      gnt      <= gnt_nx;
      rnd_data <= pop ? fifo_rd : '0;
    end
  end

  prng_zero_fifo #(.W(RND_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (prng_data),
    .rd_data (fifo_rd),
    .level   (level)
  );

`ifdef PRNG_ARB_STATS_EN
  logic [STAT_W-1:0] words_q [NUM_REQ];
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '{default: '0};
      stall_q <= '0;
    end else if (flush) begin
      words_q <= '{default: '0};
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_nx[i] && words_q[i] != '1) words_q[i] <= words_q[i] + 1'b1;
      end
      if (req != '0 && level == '0 && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_words[g*STAT_W +: STAT_W] = words_q[g];
  end
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_prng_share_arbiter.sv
// Directed bench for prng_share_arbiter: round robin, burst lock, full FIFO, flush, stalls.
module tb_prng_share_arbiter;
  import prng_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prng_valid = 1'b0;
  logic [15:0] prng_data = '0;
  logic        flush = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  lock = '0;
  logic        prng_ready;
  logic [2:0]  gnt;
  logic [15:0] rnd_data;
  logic [2:0]  level;
  arb_state_e  state;
`ifdef PRNG_ARB_STATS_EN
  logic [47:0] stat_words;
  logic [15:0] stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  prng_share_arbiter #(.NUM_REQ(3), .RND_W(16), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prng_valid (prng_valid),
    .prng_data  (prng_data),
    .prng_ready (prng_ready),
    .flush      (flush),
    .req        (req),
    .lock       (lock),
    .gnt        (gnt),
    .rnd_data   (rnd_data),
    .level      (level),
`ifdef PRNG_ARB_STATS_EN
    .stat_words (stat_words),
    .stat_stall (stat_stall),
`endif
    .state      (state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    prng_valid = 1'b1;
    prng_data  = d;
    step();
    prng_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; prng_valid = 1'b1; prng_data = 16'h1234;
    repeat (3) step();
    checks++; if (prng_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", prng_ready); end
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    checks++; if (rnd_data !== 16'h0) begin errors++; $display("FAIL reset_rnd: got %h expected 0000", rnd_data); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (state !== ARB) begin errors++; $display("FAIL reset_state: got %0d expected ARB", state); end
    rst_n = 1'b1;
    step();
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL reset_first_push: got %0d expected 1", level); end
    prng_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_flush_level: got %0d expected 0", level); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g [3];
    logic [15:0] exp_d [3];
    exp_g = '{3'b001, 3'b010, 3'b100};
    exp_d = '{16'hA001, 16'hA002, 16'hA003};
    for (int i = 0; i < 3; i++) push_word(exp_d[i]);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL rr_fill: got %0d expected 3", level); end
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", i, gnt, exp_g[i]); end
      checks++; if (rnd_data !== exp_d[i]) begin errors++; $display("FAIL rr_data%0d: got %h expected %h", i, rnd_data, exp_d[i]); end
      checks++; if (level !== 3'(2 - i)) begin errors++; $display("FAIL rr_level%0d: got %0d expected %0d", i, level, 2 - i); end
    end
    req = 3'b000;
    step();
    checks++; if (gnt !== 3'b000 || rnd_data !== 16'h0) begin errors++; $display("FAIL rr_idle: got gnt %b data %h expected 000 0000", gnt, rnd_data); end
  endtask

  task automatic test_lock();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) push_word(16'hB001 + 16'(i));
    checks++; if (level !== 3'd4 || prng_ready !== 1'b0) begin errors++; $display("FAIL lock_fill: got level %0d ready %b expected 4 0", level, prng_ready); end
    req = 3'b111; lock = 3'b001;
    for (int i = 0; i < 4; i++) begin
      step();
      d = 16'hB001 + 16'(i);
      checks++; if (gnt !== 3'b001 || rnd_data !== d) begin errors++; $display("FAIL lock_burst%0d: got gnt %b data %h expected 001 %h", i, gnt, rnd_data, d); end
    end
    checks++; if (state !== LOCK) begin errors++; $display("FAIL lock_state: got %0d expected LOCK", state); end
    lock = 3'b000; req = 3'b110;
    step();
    checks++; if (gnt !== 3'b000 || state !== ARB) begin errors++; $display("FAIL lock_exit: got gnt %b state %0d expected 000 ARB", gnt, state); end
    push_word(16'hB005);
    step();
    checks++; if (gnt !== 3'b010 || rnd_data !== 16'hB005) begin errors++; $display("FAIL lock_after: got gnt %b data %h expected 010 b005", gnt, rnd_data); end
    req = 3'b000;
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push_word(16'hC001 + 16'(i));
    checks++; if (prng_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", prng_ready); end
    prng_valid = 1'b1; prng_data = 16'hC005; req = 3'b100;
    step();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_level: got %0d expected 3", level); end
    checks++; if (gnt !== 3'b100 || rnd_data !== 16'hC001) begin errors++; $display("FAIL full_gnt: got gnt %b data %h expected 100 c001", gnt, rnd_data); end
    prng_valid = 1'b0; req = 3'b000;
    step();
    checks++; if (gnt !== 3'b000 || rnd_data !== 16'h0 || level !== 3'd3) begin errors++; $display("FAIL full_idle: got gnt %b data %h level %0d expected 000 0000 3", gnt, rnd_data, level); end
  endtask

  task automatic test_flush();
    req = 3'b001; lock = 3'b001; prng_valid = 1'b1; prng_data = 16'hC006;
    step();
    checks++; if (gnt !== 3'b001 || rnd_data !== 16'hC002) begin errors++; $display("FAIL flush_pre_gnt: got gnt %b data %h expected 001 c002", gnt, rnd_data); end
    checks++; if (state !== LOCK || level !== 3'd3) begin errors++; $display("FAIL flush_pre_state: got state %0d level %0d expected LOCK 3", state, level); end
    flush = 1'b1; prng_data = 16'hD000;
    step();
    checks++; if (level !== 3'd0 || gnt !== 3'b000 || rnd_data !== 16'h0) begin errors++; $display("FAIL flush_cycle: got level %0d gnt %b data %h expected 0 000 0000", level, gnt, rnd_data); end
    checks++; if (state !== ARB) begin errors++; $display("FAIL flush_state: got %0d expected ARB", state); end
    flush = 1'b0; prng_valid = 1'b0; lock = 3'b000;
    step();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL flush_no_stale: got %b expected 000", gnt); end
    push_word(16'hE001);
    step();
    checks++; if (gnt !== 3'b001 || rnd_data !== 16'hE001) begin errors++; $display("FAIL flush_fresh: got gnt %b data %h expected 001 e001", gnt, rnd_data); end
    req = 3'b000;
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    req = 3'b001;
    for (int i = 0; i < 6; i++) begin
      prng_valid = 1'b1; prng_data = 16'h9000 + 16'(i);
      step();
      if (i == 0) begin
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL b2b_latency: got %b expected 000", gnt); end
      end else begin
        d = 16'h9000 + 16'(i - 1);
        checks++; if (gnt !== 3'b001 || rnd_data !== d || level !== 3'd1) begin errors++; $display("FAIL b2b_word%0d: got gnt %b data %h level %0d expected 001 %h 1", i, gnt, rnd_data, level, d); end
      end
    end
    prng_valid = 1'b0;
    step();
    checks++; if (gnt !== 3'b001 || rnd_data !== 16'h9005 || level !== 3'd0) begin errors++; $display("FAIL b2b_last: got gnt %b data %h level %0d expected 001 9005 0", gnt, rnd_data, level); end
    req = 3'b000;
    step();
    checks++; if (gnt !== 3'b000 || rnd_data !== 16'h0) begin errors++; $display("FAIL b2b_idle: got gnt %b data %h expected 000 0000", gnt, rnd_data); end
  endtask

  task automatic test_stall();
    int ngnt;
    ngnt = 0;
    flush = 1'b1;
    step();
    flush = 1'b0; req = 3'b010;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin prng_valid = 1'b1; prng_data = 16'hF001; end
      step();
      if (gnt != 3'b000) ngnt++;
    end
    prng_valid = 1'b0;
    checks++; if (ngnt !== 0) begin errors++; $display("FAIL stall_early_gnt: got %0d grants expected 0", ngnt); end
    step();
    checks++; if (gnt !== 3'b010 || rnd_data !== 16'hF001) begin errors++; $display("FAIL stall_gnt: got gnt %b data %h expected 010 f001", gnt, rnd_data); end
    req = 3'b000;
    step();
    checks++; if (gnt !== 3'b000 || level !== 3'd0) begin errors++; $display("FAIL stall_single: got gnt %b level %0d expected 000 0", gnt, level); end
`ifdef PRNG_ARB_STATS_EN
    checks++; if (stat_stall !== 16'd10) begin errors++; $display("FAIL stat_stall: got %0d expected 10", stat_stall); end
    checks++; if (stat_words[31:16] !== 16'd1) begin errors++; $display("FAIL stat_words1: got %0d expected 1", stat_words[31:16]); end
    checks++; if (stat_words[15:0] !== 16'd0) begin errors++; $display("FAIL stat_words0: got %0d expected 0", stat_words[15:0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_flush();
    test_back_to_back();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prng_share_arbiter.md
# prng_share_arbiter

Distributes fresh 16-bit randomness from the single PRNG to the masked gadgets of the decapsulation datapath (masked decode in poly-to-message, masked compare, masked re-encryption). It buffers PRNG words in a small zeroizing FIFO and grants each word to exactly one requester, never twice. Arbitration is round-robin, with an optional burst lock so a 256-coefficient masked-decode pass gets uninterrupted randomness.

## Interface
Parameters:
- NUM_REQ, 3, number of requesting gadgets (2..8)
- RND_W, 16, randomness word width
- FIFO_DEPTH, 4, buffered PRNG words (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- prng_valid  in  1  PRNG word available
- prng_data  in  RND_W  PRNG word
- prng_ready  out  1  arbiter accepts word; equals (level < FIFO_DEPTH)
- flush  in  1  discard all buffered words, release lock
- req  in  NUM_REQ  per-requester word request, held until granted
- lock  in  NUM_REQ  requester wants burst ownership
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: word delivered
- rnd_data  out  RND_W  granted word, valid only while gnt≠0, else 0
- level  out  $clog2(FIFO_DEPTH)+1  buffered word count

## Operation
- Push when prng_valid && prng_ready. Pop when a grant is issued. Each word leaves the FIFO exactly once. A popped entry is overwritten with 0 in the same cycle.
- Push and pop in the same cycle: level is unchanged. prng_ready depends only on level, so no push occurs at full even with a concurrent pop.
- FSM states:
  - ARB: if level>0 and req≠0, grant the first set req at or after rr_ptr, cyclically. rr_ptr ← (winner+1) mod NUM_REQ. If lock[winner]=1 in the grant cycle, go to LOCK with owner=winner.
  - LOCK: only req[owner] is served, one word per cycle while level>0. Other requests wait. When lock[owner]=0, go to ARB with rr_ptr ← (owner+1) mod NUM_REQ. No grant is issued in the exit cycle unless owner also has req high, in which case the owner gets that last word.
- flush has priority over everything:
  - level ← 0 and all entries are zeroed.
  - No grant and no push that cycle.
  - FSM goes to ARB; rr_ptr is unchanged.
- Empty FIFO: no grant. Requests stay pending without loss. req may be dropped before grant.
- Reset mid-operation: the FIFO contents, lock and pending grant are abandoned. Requesters must re-request.

## Timing
- Reset values:
  - gnt=0, rnd_data=0, level=0, prng_ready=1
  - FSM=ARB, rr_ptr=0, owner=0, FIFO entries=0
- gnt and rnd_data are registered. A grant appears 1 cycle after the cycle in which req is sampled high with level>0.
- A word pushed at edge N can be granted at edge N+1 at the earliest, i.e. 2 cycles from prng_valid to gnt.
- Sustained throughput is one word per cycle when PRNG supply and req are continuous.
- rnd_data returns to 0 the cycle after each gnt, so randomness is never visible while idle.

## Configuration
- PRNG_ARB_STATS_EN defined:
  - Adds output stat_words (NUM_REQ×16 bits), a per-requester count of granted words.
  - Adds output stat_stall (16 bits), counting cycles with req≠0 and level=0.
  - Counters saturate at 0xFFFF, clear on reset and on flush.
- Not defined: the ports and counters are absent and the logic is otherwise identical.

## Structure
- Package prng_arb_pkg:
  - State enum {ARB, LOCK}
  - Default parameter constants
  - Function rr_pick(req, ptr) returning the winner index and a valid flag
- Sub-module prng_zero_fifo: synchronous FIFO with push/pop/flush, zero-on-pop, level output.
- Top-level: FSM, round-robin pointer, grant registers, optional stats.

## Test plan
- Reset with prng_valid=1 and data 0x1234 → prng_ready=1, gnt=0, rnd_data=0. After release, level increments to 1 on the next edge.
- FIFO holds 0xA001,0xA002,0xA003; req=3'b111 continuously, no lock → gnt sequence 001,010,100 with rnd_data 0xA001,0xA002,0xA003; level 3→0; rnd_data=0 afterwards.
- Requester 0 asserts lock with req; requesters 1 and 2 also request; 4 words supplied → all 4 granted to req 0. lock[0] dropped → next grant goes to requester 1.
- FIFO full (level=4), prng_valid=1 with pop in the same cycle → prng_ready=0, no push, level 4→3.
- flush while in LOCK with level=3 → next cycle level=0, gnt=0, FSM=ARB; no word that was in the FIFO before the flush is ever delivered.
- req=3'b010 with empty FIFO for 10 cycles, then one word → exactly one gnt=010. With PRNG_ARB_STATS_EN, stat_stall=10 and stat_words[1]=1.
